bidir_shift_loader: RTL and testbench



---
 rtl/bidir_shift_loader.sv | 97 +++++++++
 tb/tb_bidir_shift_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bidir_shift_loader.sv
// bidir_shift_loader: serializes a parallel word onto mode/Dr/Dl so a WIDTH-bit bidirectional shift register ends up holding it.
// Optional LOADER_QUEUE_EN adds a one-entry pending buffer so a second load can follow with no gap.
module bidir_shift_loader #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] data,
    output logic             mode,
    output logic             Dr,
    output logic             Dl,
    output logic             busy,
    output logic             ready,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n, w_idx;
    logic [WIDTH-1:0] r_ord, w_in_ord, w_src_ord;
    logic r_dir, r_mode, r_dr, r_dl, r_done;
    logic w_src_dir, w_last, w_launch, w_shifting, w_bit, w_dir_n;
    logic w_mode_n, w_dr_n, w_dl_n;
    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        for (int i = 0; i < WIDTH; i++) rev[i] = v[WIDTH-1-i];
    endfunction
    // Words are stored in drive order: bit k of r_ord is the k-th bit sent.
    assign w_in_ord = dir ? rev(data) : data;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(WIDTH-1));
`ifdef LOADER_QUEUE_EN
    logic r_pend_valid, r_pend_dir;
    logic [WIDTH-1:0] r_pend_ord;
    assign w_launch  = r_pend_valid ? (w_last || r_state != SHIFT) : (start && r_state != SHIFT);
    assign w_src_ord = r_pend_valid ? r_pend_ord : w_in_ord;
    assign w_src_dir = r_pend_valid ? r_pend_dir : dir;
    assign ready     = ~r_pend_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_ord   <= '0;
            r_pend_dir   <= 1'b0;
        end else if (w_launch && r_pend_valid) begin
            r_pend_valid <= 1'b0;
        end else if (start && !r_pend_valid && r_state == SHIFT) begin
            r_pend_valid <= 1'b1;
            r_pend_ord   <= w_in_ord;
            r_pend_dir   <= dir;
        end
    end
`else
    assign w_launch  = start && r_state != SHIFT;
    assign w_src_ord = w_in_ord;
    assign w_src_dir = dir;
    assign ready     = ~busy;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ord   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= 1'b0;
            r_dr    <= 1'b0;
            r_dl    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_ord   <= w_launch ? w_src_ord : r_ord;
            r_dir   <= w_dir_n;
            r_mode  <= w_mode_n;
            r_dr    <= w_dr_n;
            r_dl    <= w_dl_n;
            r_done  <= w_last;
        end
    end
    always_comb begin
        w_state_n = w_launch ? SHIFT : (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : IDLE;
    end
    always_comb begin
        w_idx      = r_cnt + CW'(1);
        w_shifting = w_launch || (r_state == SHIFT && !w_last);
        w_cnt_n    = (r_state == SHIFT && !w_last) ? w_idx : '0;
        w_dir_n    = w_launch ? w_src_dir : r_dir;
        w_mode_n   = w_launch ? w_src_dir : r_mode;
        w_bit      = w_launch ? w_src_ord[0] : r_ord[w_idx];
        w_dr_n     = w_shifting && !w_dir_n && w_bit;
        w_dl_n     = w_shifting && w_dir_n && w_bit;
    end
    assign mode = r_mode;
    assign Dr   = r_dr;
    assign Dl   = r_dl;
    assign busy = (r_state == SHIFT);
    assign done = r_done;
endmodule

// File: tb/tb_bidir_shift_loader.sv
// tb_bidir_shift_loader: directed checks of bidir_shift_loader driving a model of the downstream 4-bit register.
module tb_bidir_shift_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic dir = 1'b0;
    logic [3:0] data = 4'b0000;
    logic mode, Dr, Dl, busy, ready, done;
    logic [5:0] obs;
    logic [3:0] ds_q = 4'b0000;
    int pass_cnt = 0;
    int total_cnt = 0;
`ifdef LOADER_QUEUE_EN
    localparam logic RB = 1'b1;
`else
    localparam logic RB = 1'b0;
`endif

    bidir_shift_loader #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .data(data),
        .mode(mode), .Dr(Dr), .Dl(Dl), .busy(busy), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;
    assign obs = {mode, Dr, Dl, busy, ready, done};

    // Downstream register: mode=0 shifts Dr in at the top, mode=1 shifts Dl in at the bottom.
    always @(posedge clk) ds_q <= mode ? {ds_q[2:0], Dl} : {Dr, ds_q[3:1]};

    task automatic kick(input logic d, input logic [3:0] w);
        start = 1'b1;
        dir = d;
        data = w;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (obs !== 6'b000010) $display("FAIL reset_held obs=%b exp=%b", obs, 6'b000010); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (obs !== 6'b000010) $display("FAIL reset_idle obs=%b exp=%b", obs, 6'b000010); else pass_cnt++;
    endtask

    task automatic test_right;
        logic [3:0] w;
        w = 4'b1010;
        kick(1'b0, w);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (obs !== {1'b0, w[k], 1'b0, 1'b1, RB, 1'b0}) $display("FAIL right_bit%0d obs=%b exp=%b", k, obs, {1'b0, w[k], 1'b0, 1'b1, RB, 1'b0});
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (obs !== 6'b000011) $display("FAIL right_done obs=%b exp=%b", obs, 6'b000011); else pass_cnt++;
        total_cnt++;
        if ({ds_q, ~ds_q} !== 8'b1010_0101) $display("FAIL right_q q=%b qbar=%b exp=1010/0101", ds_q, ~ds_q); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (obs !== 6'b000010) $display("FAIL right_idle obs=%b exp=%b", obs, 6'b000010); else pass_cnt++;
    endtask

    task automatic test_left;
        logic [3:0] w;
        w = 4'b1101;
        kick(1'b1, w);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (obs !== {1'b1, 1'b0, w[3-k], 1'b1, RB, 1'b0}) $display("FAIL left_bit%0d obs=%b exp=%b", k, obs, {1'b1, 1'b0, w[3-k], 1'b1, RB, 1'b0});
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (obs !== 6'b100011) $display("FAIL left_done obs=%b exp=%b", obs, 6'b100011); else pass_cnt++;
        total_cnt++;
        if (ds_q !== 4'b1101) $display("FAIL left_q q=%b exp=%b", ds_q, 4'b1101); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (obs !== 6'b100010) $display("FAIL left_idle_mode_hold obs=%b exp=%b", obs, 6'b100010); else pass_cnt++;
    endtask

    task automatic test_ignore_busy;
        logic [3:0] w;
        int dones;
        w = 4'b0011;
        dones = 0;
        kick(1'b0, w);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (obs !== {1'b0, w[k], 1'b0, 1'b1, 1'b0, 1'b0}) $display("FAIL ignore_bit%0d obs=%b exp=%b", k, obs, {1'b0, w[k], 1'b0, 1'b1, 1'b0, 1'b0});
            else pass_cnt++;
            start = (k == 1);
            dir = (k >= 1);
            data = (k >= 1) ? 4'b1111 : w;
            @(negedge clk);
        end
        start = 1'b0;
        total_cnt++;
        if (obs !== 6'b000011) $display("FAIL ignore_done obs=%b exp=%b", obs, 6'b000011); else pass_cnt++;
        total_cnt++;
        if (ds_q !== 4'b0011) $display("FAIL ignore_q q=%b exp=%b", ds_q, 4'b0011); else pass_cnt++;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL ignore_extra_activity cycles=%0d exp=0", dones); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        logic [3:0] w;
        int dones;
        dones = 0;
        kick(1'b1, 4'b0101);
        total_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, RB, 1'b0}) $display("FAIL abort_bit0 obs=%b exp=%b", obs, {1'b1, 1'b0, 1'b0, 1'b1, RB, 1'b0}); else pass_cnt++;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (obs !== 6'b000010) $display("FAIL async_reset obs=%b exp=%b", obs, 6'b000010); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL abort_no_done cycles=%0d exp=0", dones); else pass_cnt++;
        w = 4'b0110;
        kick(1'b1, w);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (obs !== {1'b1, 1'b0, w[3-k], 1'b1, RB, 1'b0}) $display("FAIL fresh_bit%0d obs=%b exp=%b", k, obs, {1'b1, 1'b0, w[3-k], 1'b1, RB, 1'b0});
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (obs !== 6'b100011) $display("FAIL fresh_done obs=%b exp=%b", obs, 6'b100011); else pass_cnt++;
        total_cnt++;
        if (ds_q !== 4'b0110) $display("FAIL fresh_q q=%b exp=%b", ds_q, 4'b0110); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [3:0] a, b;
        a = 4'b1001;
        b = 4'b0110;
        kick(1'b0, a);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (obs !== {1'b0, a[k], 1'b0, 1'b1, RB, 1'b0}) $display("FAIL b2b_a_bit%0d obs=%b exp=%b", k, obs, {1'b0, a[k], 1'b0, 1'b1, RB, 1'b0});
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (obs !== 6'b000011) $display("FAIL b2b_a_done obs=%b exp=%b", obs, 6'b000011); else pass_cnt++;
        total_cnt++;
        if (ds_q !== a) $display("FAIL b2b_a_q q=%b exp=%b", ds_q, a); else pass_cnt++;
        kick(1'b1, b);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (obs !== {1'b1, 1'b0, b[3-k], 1'b1, RB, 1'b0}) $display("FAIL b2b_b_bit%0d obs=%b exp=%b", k, obs, {1'b1, 1'b0, b[3-k], 1'b1, RB, 1'b0});
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (obs !== 6'b100011) $display("FAIL b2b_b_done obs=%b exp=%b", obs, 6'b100011); else pass_cnt++;
        total_cnt++;
        if (ds_q !== b) $display("FAIL b2b_b_q q=%b exp=%b", ds_q, b); else pass_cnt++;
        @(negedge clk);
    endtask

`ifdef LOADER_QUEUE_EN
    task automatic test_queue;
        logic [3:0] a, b;
        a = 4'b1000;
        b = 4'b0001;
        kick(1'b0, a);
        total_cnt++;
        if (obs !== {1'b0, a[0], 1'b0, 1'b1, 1'b1, 1'b0}) $display("FAIL queue_a_bit0 obs=%b exp=%b", obs, {1'b0, a[0], 1'b0, 1'b1, 1'b1, 1'b0}); else pass_cnt++;
        kick(1'b1, b);
        for (int k = 1; k < 4; k++) begin
            total_cnt++;
            if (obs !== {1'b0, a[k], 1'b0, 1'b1, 1'b0, 1'b0}) $display("FAIL queue_a_bit%0d obs=%b exp=%b", k, obs, {1'b0, a[k], 1'b0, 1'b1, 1'b0, 1'b0});
            else pass_cnt++;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (obs !== {1'b1, 1'b0, b[3-k], 1'b1, 1'b1, k == 0}) $display("FAIL queue_b_bit%0d obs=%b exp=%b", k, obs, {1'b1, 1'b0, b[3-k], 1'b1, 1'b1, k == 0});
            else pass_cnt++;
            if (k == 0) begin
                total_cnt++;
                if (ds_q !== a) $display("FAIL queue_a_q q=%b exp=%b", ds_q, a); else pass_cnt++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (obs !== 6'b100011) $display("FAIL queue_b_done obs=%b exp=%b", obs, 6'b100011); else pass_cnt++;
        total_cnt++;
        if (ds_q !== b) $display("FAIL queue_b_q q=%b exp=%b", ds_q, b); else pass_cnt++;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_right();
        test_left();
`ifdef LOADER_QUEUE_EN
        test_queue();
`else
        test_ignore_busy();
`endif
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
